// File: rtl/ntt_writeback_scheduler.sv
// Write-back scheduler for an in-place radix-2 NTT: delays issued read-pair addresses by the
// butterfly latency, pairs them with returning results, and tracks stage/transform completion.
module ntt_writeback_scheduler #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 4,
   parameter int LOG_N   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr_0,
   input  logic [ADDR_W-1:0] iss_addr_1,
   output logic              iss_hazard,
   input  logic              bf_valid,
   input  logic [DATA_W-1:0] bf_data_0,
   input  logic [DATA_W-1:0] bf_data_1,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr_0,
   output logic [ADDR_W-1:0] wr_addr_1,
   output logic [DATA_W-1:0] wr_data_0,
   output logic [DATA_W-1:0] wr_data_1,
   output logic [3:0]        stage,
   output logic              stage_done,
   output logic              ntt_done,
   output logic              align_err
);

   localparam int              CNT_W      = LOG_N - 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = '1;          // N/2 - 1
   localparam logic [3:0]       STAGE_LAST = 4'(LOG_N - 1);

   logic [LATENCY-1:0] dl_v;
   logic [ADDR_W-1:0]  dl_a0 [LATENCY];
   logic [ADDR_W-1:0]  dl_a1 [LATENCY];
   logic [CNT_W-1:0]   wr_cnt;

   logic head_v;
   logic pair;
   logic misalign;

   assign head_v   = dl_v[LATENCY-1];
   assign pair     = head_v & bf_valid;
   assign misalign = head_v ^ bf_valid;

   function automatic logic pair_hit(input logic [ADDR_W-1:0] x0, input logic [ADDR_W-1:0] x1,
                                     input logic [ADDR_W-1:0] y0, input logic [ADDR_W-1:0] y1);
      return (x0 == y0) || (x0 == y1) || (x1 == y0) || (x1 == y1);
   endfunction

   // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         if (dl_v[i] && pair_hit(iss_addr_0, iss_addr_1, dl_a0[i], dl_a1[i])) hit = 1'b1;
      end
      if (wr_en && pair_hit(iss_addr_0, iss_addr_1, wr_addr_0, wr_addr_1)) hit = 1'b1;
      iss_hazard = iss_valid & hit;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_v <= '0;
      end else if (start) begin
         dl_v <= '0;
      end else begin
         for (int i = LATENCY - 1; i > 0; i--) dl_v[i] <= dl_v[i-1];
         dl_v[0] <= iss_valid;
      end
   end

   // NOTE: the address payload is deliberately not reset; it is only observed qualified by dl_v.
   always_ff @(posedge clk) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
         dl_a0[i] <= dl_a0[i-1];
         dl_a1[i] <= dl_a1[i-1];
      end
      dl_a0[0] <= iss_addr_0;
      dl_a1[0] <= iss_addr_1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en      <= 1'b0;
         wr_addr_0  <= '0;
         wr_addr_1  <= '0;
         wr_data_0  <= '0;
         wr_data_1  <= '0;
         wr_cnt     <= '0;
         stage      <= '0;
         stage_done <= 1'b0;
         ntt_done   <= 1'b0;
         align_err  <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         stage_done <= 1'b0;
         ntt_done   <= 1'b0;
         if (start) begin
            wr_cnt    <= '0;
            stage     <= '0;
            align_err <= 1'b0;
         end else begin
            if (misalign) align_err <= 1'b1;
            if (pair) begin
               wr_en     <= 1'b1;
               wr_addr_0 <= dl_a0[LATENCY-1];
               wr_addr_1 <= dl_a1[LATENCY-1];
               wr_data_0 <= bf_data_0;
               wr_data_1 <= bf_data_1;
               // Last butterfly of a stage wraps the counter and advances the stage.
               if (wr_cnt == CNT_LAST) begin
                  wr_cnt     <= '0;
                  stage_done <= 1'b1;
                  if (stage == STAGE_LAST) begin
                     stage    <= '0;
                     ntt_done <= 1'b1;
                  end else begin
                     stage <= stage + 4'd1;
                  end
               end else begin
                  wr_cnt <= wr_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ntt_writeback_scheduler.sv
// Directed self-checking bench for ntt_writeback_scheduler (LATENCY=4, LOG_N=10).
module tb_ntt_writeback_scheduler;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        iss_valid = 1'b0;
   logic [9:0]  iss_addr_0 = '0;
   logic [9:0]  iss_addr_1 = '0;
   logic        iss_hazard;
   logic        bf_valid = 1'b0;
   logic [31:0] bf_data_0 = '0;
   logic [31:0] bf_data_1 = '0;
   logic        wr_en;
   logic [9:0]  wr_addr_0, wr_addr_1;
   logic [31:0] wr_data_0, wr_data_1;
   logic [3:0]  stage;
   logic        stage_done, ntt_done, align_err;

   int n_cmp = 0;
   int n_bad = 0;

   ntt_writeback_scheduler #(.ADDR_W(10), .DATA_W(32), .LATENCY(LAT), .LOG_N(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .iss_valid(iss_valid), .iss_addr_0(iss_addr_0), .iss_addr_1(iss_addr_1),
      .iss_hazard(iss_hazard),
      .bf_valid(bf_valid), .bf_data_0(bf_data_0), .bf_data_1(bf_data_1),
      .wr_en(wr_en), .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
      .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
      .stage(stage), .stage_done(stage_done), .ntt_done(ntt_done), .align_err(align_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; iss_valid = 1'b0; bf_valid = 1'b0;
   endtask

   task automatic do_start();
      idle_inputs();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Aligned stream: issue k at cycle k, its result at cycle k+LAT; checks every write.
   task automatic run_aligned(input int count, output int writes, output int sds,
                              output int ntts, output int last_sd, output int ntt_at);
      logic [9:0] ea0;
      writes = 0; sds = 0; ntts = 0; last_sd = -1; ntt_at = -1;
      for (int c = 0; c < count + LAT; c++) begin
         iss_valid  = (c < count);
         iss_addr_0 = 10'(c % 512);
         iss_addr_1 = 10'(c % 512) | 10'h200;
         bf_valid   = (c >= LAT);
         bf_data_0  = 32'(c - LAT);
         bf_data_1  = ~32'(c - LAT);
         #1;
         n_cmp++;
         if (iss_hazard !== 1'b0) begin
            n_bad++; $display("FAIL stream_hazard c=%0d got %b want 0", c, iss_hazard);
         end
         step();
         if (wr_en === 1'b1) begin
            ea0 = 10'((c - LAT) % 512);
            writes++;
            n_cmp++;
            if ({wr_addr_0, wr_addr_1, wr_data_0, wr_data_1} !==
                {ea0, ea0 | 10'h200, 32'(c - LAT), ~32'(c - LAT)}) begin
               n_bad++;
               $display("FAIL stream_write #%0d got %h/%h %h/%h want %h/%h %h/%h", writes,
                        wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
                        ea0, ea0 | 10'h200, 32'(c - LAT), ~32'(c - LAT));
            end
            n_cmp++;
            if (stage_done !== (writes % 512 == 0)) begin
               n_bad++; $display("FAIL stage_done_pos write #%0d got %b", writes, stage_done);
            end
            if (stage_done === 1'b1) begin
               sds++; last_sd = writes;
               n_cmp++;
               if (stage !== 4'((writes / 512) % 10)) begin
                  n_bad++; $display("FAIL stage_adv write #%0d got %0d want %0d", writes, stage,
                                    (writes / 512) % 10);
               end
            end
            if (ntt_done === 1'b1) begin ntts++; ntt_at = writes; end
         end else if (stage_done !== 1'b0 || ntt_done !== 1'b0) begin
            n_cmp++; n_bad++;
            $display("FAIL pulse_without_write c=%0d got sd=%b nd=%b want 0", c, stage_done, ntt_done);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      step(); step();
      n_cmp++;
      if ({wr_en, stage_done, ntt_done, align_err, iss_hazard} !== 5'b0) begin
         n_bad++; $display("FAIL reset_flags got %b want 00000",
                           {wr_en, stage_done, ntt_done, align_err, iss_hazard});
      end
      n_cmp++;
      if ({wr_addr_0, wr_addr_1, wr_data_0, wr_data_1, stage} !== '0) begin
         n_bad++; $display("FAIL reset_regs got %h %h %h %h %h want 0",
                           wr_addr_0, wr_addr_1, wr_data_0, wr_data_1, stage);
      end
      #2 rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      int writes = 0;
      idle_inputs();
      iss_valid = 1'b1; iss_addr_0 = 10'h005; iss_addr_1 = 10'h006;
      step();
      idle_inputs();
      for (int c = 1; c < LAT; c++) begin
         step();
         if (wr_en === 1'b1) writes++;
      end
      bf_valid = 1'b1; bf_data_0 = 32'h11; bf_data_1 = 32'h22;
      step();
      idle_inputs();
      n_cmp++;
      if (writes !== 0) begin n_bad++; $display("FAIL single_early got %0d writes want 0", writes); end
      n_cmp++;
      if ({wr_en, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1} !== {1'b1, 10'h005, 10'h006, 32'h11, 32'h22}) begin
         n_bad++; $display("FAIL single_write got %b %h/%h %h/%h want 1 005/006 11/22",
                           wr_en, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1);
      end
      n_cmp++;
      if ({stage_done, ntt_done, align_err} !== 3'b0) begin
         n_bad++; $display("FAIL single_flags got %b want 000", {stage_done, ntt_done, align_err});
      end
      step();
      n_cmp++;
      if ({wr_en, wr_addr_0, wr_data_1} !== {1'b0, 10'h005, 32'h22}) begin
         n_bad++; $display("FAIL single_hold got %b %h %h want 0 005 22", wr_en, wr_addr_0, wr_data_1);
      end
   endtask

   task automatic test_full_stage();
      int w, s, n, lsd, nat;
      do_start();
      run_aligned(512, w, s, n, lsd, nat);
      n_cmp++;
      if ({w, s, n, lsd} !== {32'd512, 32'd1, 32'd0, 32'd512}) begin
         n_bad++; $display("FAIL stage_counts got w=%0d sd=%0d nd=%0d at=%0d want 512 1 0 512", w, s, n, lsd);
      end
      n_cmp++;
      if (stage !== 4'd1) begin n_bad++; $display("FAIL stage_after got %0d want 1", stage); end
   endtask

   task automatic test_full_transform();
      int w, s, n, lsd, nat;
      do_start();
      n_cmp++;
      if (stage !== 4'd0) begin n_bad++; $display("FAIL start_clears_stage got %0d want 0", stage); end
      run_aligned(5120, w, s, n, lsd, nat);
      n_cmp++;
      if ({w, s, n} !== {32'd5120, 32'd10, 32'd1}) begin
         n_bad++; $display("FAIL ntt_counts got w=%0d sd=%0d nd=%0d want 5120 10 1", w, s, n);
      end
      n_cmp++;
      if ({lsd, nat} !== {32'd5120, 32'd5120}) begin
         n_bad++; $display("FAIL ntt_pos got sd_at=%0d nd_at=%0d want 5120 5120", lsd, nat);
      end
      n_cmp++;
      if (stage !== 4'd0) begin n_bad++; $display("FAIL ntt_stage_wrap got %0d want 0", stage); end
   endtask

   task automatic test_misalign();
      int writes = 0;
      do_start();
      for (int c = 0; c <= LAT + 1; c++) begin
         iss_valid = (c == 0); iss_addr_0 = 10'h005; iss_addr_1 = 10'h006;
         bf_valid = (c == LAT + 1); bf_data_0 = 32'h33; bf_data_1 = 32'h44;
         step();
         if (wr_en === 1'b1) writes++;
         n_cmp++;
         if (align_err !== (c + 1 >= LAT + 1)) begin
            n_bad++; $display("FAIL misalign_flag cycle %0d got %b want %b", c + 1, align_err, c + 1 >= LAT + 1);
         end
      end
      idle_inputs();
      repeat (85) begin step(); if (wr_en === 1'b1) writes++; end
      n_cmp++;
      if ({align_err, 32'(writes)} !== {1'b1, 32'd0}) begin
         n_bad++; $display("FAIL misalign_sticky got err=%b writes=%0d want 1 0", align_err, writes);
      end
      do_start();
      n_cmp++;
      if (align_err !== 1'b0) begin n_bad++; $display("FAIL misalign_clear got %b want 0", align_err); end
   endtask

   task automatic test_hazard();
      do_start();
      iss_valid = 1'b1; iss_addr_0 = 10'h000; iss_addr_1 = 10'h200;
      #1; n_cmp++;
      if (iss_hazard !== 1'b0) begin n_bad++; $display("FAIL hazard_empty got %b want 0", iss_hazard); end
      step();
      idle_inputs();
      step();
      iss_valid = 1'b1; iss_addr_0 = 10'h200; iss_addr_1 = 10'h300;
      #1; n_cmp++;
      if (iss_hazard !== 1'b1) begin n_bad++; $display("FAIL hazard_hit got %b want 1", iss_hazard); end
      step();
      iss_addr_0 = 10'h001; iss_addr_1 = 10'h201;
      #1; n_cmp++;
      if (iss_hazard !== 1'b0) begin n_bad++; $display("FAIL hazard_clear got %b want 0", iss_hazard); end
      step();
      iss_valid = 1'b0; bf_valid = 1'b1; bf_data_0 = 32'h5; bf_data_1 = 32'h6;
      step();
      bf_valid = 1'b0;
      n_cmp++;
      if ({wr_en, wr_addr_0, wr_addr_1} !== {1'b1, 10'h000, 10'h200}) begin
         n_bad++; $display("FAIL hazard_write got %b %h/%h want 1 000/200", wr_en, wr_addr_0, wr_addr_1);
      end
      iss_valid = 1'b1; iss_addr_0 = 10'h000; iss_addr_1 = 10'h123;
      #1; n_cmp++;
      if (iss_hazard !== 1'b1) begin n_bad++; $display("FAIL hazard_outreg got %b want 1", iss_hazard); end
      iss_valid = 1'b0;
      #1; n_cmp++;
      if (iss_hazard !== 1'b0) begin n_bad++; $display("FAIL hazard_gated got %b want 0", iss_hazard); end
      step();
      iss_valid = 1'b1;
      #1; n_cmp++;
      if (iss_hazard !== 1'b0) begin n_bad++; $display("FAIL hazard_outreg_idle got %b want 0", iss_hazard); end
      iss_addr_0 = 10'h300; iss_addr_1 = 10'h3ff;
      #1; n_cmp++;
      if (iss_hazard !== 1'b1) begin n_bad++; $display("FAIL hazard_cross got %b want 1", iss_hazard); end
      idle_inputs();
      step();
   endtask

   task automatic test_start_discard();
      int writes = 0;
      idle_inputs();
      start = 1'b1; iss_valid = 1'b1; iss_addr_0 = 10'h0aa; iss_addr_1 = 10'h2aa;
      step();
      idle_inputs();
      repeat (LAT + 2) begin step(); if (wr_en === 1'b1) writes++; end
      n_cmp++;
      if ({align_err, 32'(writes)} !== {1'b0, 32'd0}) begin
         n_bad++; $display("FAIL start_discard got err=%b writes=%0d want 0 0", align_err, writes);
      end
   endtask

   task automatic test_flush();
      int writes = 0;
      int w, s, n, lsd, nat;
      do_start();
      for (int c = 0; c < 9; c++) begin
         iss_valid = (c < 3); iss_addr_0 = 10'(c + 16); iss_addr_1 = 10'(c + 16) | 10'h200;
         start = (c == 3);
         bf_valid = (c >= 4 && c < 7); bf_data_0 = 32'(c); bf_data_1 = 32'(c);
         step();
         if (wr_en === 1'b1) writes++;
      end
      idle_inputs();
      n_cmp++;
      if ({32'(writes), align_err, stage, stage_done, ntt_done} !== {32'd0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL flush got writes=%0d err=%b stage=%0d sd=%b nd=%b want 0 1 0 0 0",
                           writes, align_err, stage, stage_done, ntt_done);
      end
      do_start();
      run_aligned(512, w, s, n, lsd, nat);
      n_cmp++;
      if ({s, lsd} !== {32'd1, 32'd512}) begin
         n_bad++; $display("FAIL flush_cnt got sd=%0d at=%0d want 1 512", s, lsd);
      end
   endtask

   task automatic test_reset_mid();
      int writes = 0;
      do_start();
      for (int c = 0; c <= LAT; c++) begin
         iss_valid = (c < 3); iss_addr_0 = 10'(c + 32); iss_addr_1 = 10'(c + 32) | 10'h200;
         bf_valid = (c >= LAT); bf_data_0 = 32'hab; bf_data_1 = 32'hcd;
         step();
      end
      n_cmp++;
      if ({wr_en, wr_addr_0} !== {1'b1, 10'd32}) begin
         n_bad++; $display("FAIL pre_reset_write got %b %h want 1 020", wr_en, wr_addr_0);
      end
      #2 rst_n = 1'b0;
      #1; n_cmp++;
      if ({wr_en, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1, stage, stage_done, ntt_done, align_err} !== '0) begin
         n_bad++; $display("FAIL async_reset got %b %h/%h %h/%h st=%0d want all 0",
                           wr_en, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1, stage);
      end
      iss_valid = 1'b1; iss_addr_0 = 10'd33; iss_addr_1 = 10'd34;
      #1; n_cmp++;
      if (iss_hazard !== 1'b0) begin n_bad++; $display("FAIL reset_hazard got %b want 0", iss_hazard); end
      iss_valid = 1'b0;
      step();
      #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         bf_valid = (c < 2);
         step();
         if (wr_en === 1'b1) writes++;
      end
      idle_inputs();
      n_cmp++;
      if (writes !== 0) begin n_bad++; $display("FAIL post_reset_writes got %0d want 0", writes); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_stage();
      test_full_transform();
      test_misalign();
      test_hazard();
      test_start_discard();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
